controller: RTL and testbench



---
 rtl/controller.sv | 173 +++++++++++++++++
 tb/tb_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/controller.sv
// -----------------------------------------------------------------------------
// controller -- instruction sequencer for the 8-bit accumulator CPU.
//
// Steps an 8-phase fetch/execute cycle and decodes the current opcode and the
// ALU zero flag into memory, IR, PC and accumulator strobes. All strobes are a
// combinational decode of (state, opcode, zero).
//
// Ports:
//   clk          system clock, state advances on posedge
//   rst_         asynchronous active-low reset (state -> INST_ADDR)
//   opcode       current instruction-register opcode (typedefs::opcode_t)
//   zero         ALU accumulator-zero flag (used in ALU_OP only)
//   mem_rd       memory read strobe
//   load_ir      instruction register load
//   halt         processor halted
//   inc_pc       program counter increment
//   load_ac      accumulator load from ALU out
//   load_pc      program counter load (jump)
//   mem_wr       memory write strobe
//   instr_count  retired-instruction count, saturating at 16'hFFFF
//                (present only when CONTROLLER_INSTR_COUNT_EN is defined)
//
// Optional feature macro: CONTROLLER_INSTR_COUNT_EN
// -----------------------------------------------------------------------------

package typedefs;
  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;
endpackage

module controller (
  input  logic        clk,
  input  logic        rst_,
  input  logic [2:0]  opcode,
  input  logic        zero,
  output logic        mem_rd,
  output logic        load_ir,
  output logic        halt,
  output logic        inc_pc,
  output logic        load_ac,
  output logic        load_pc,
  output logic        mem_wr
`ifdef CONTROLLER_INSTR_COUNT_EN
  ,
  output logic [15:0] instr_count
`endif
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } state_t;

  state_t state_q, state_d;

  // Opcode class flags. Decoded through a case with an all-zero default so an
  // unknown/X opcode lands in the default and raises no opcode-dependent strobe.
  logic is_hlt, is_skz, is_sto, is_jmp, aluop;

  always_comb begin
    is_hlt = 1'b0;
    is_skz = 1'b0;
    is_sto = 1'b0;
    is_jmp = 1'b0;
    aluop  = 1'b0;
    case (opcode)
      typedefs::HLT: is_hlt = 1'b1;
      typedefs::SKZ: is_skz = 1'b1;
      typedefs::ADD,
      typedefs::AND,
      typedefs::XOR,
      typedefs::LDA: aluop  = 1'b1;
      typedefs::STO: is_sto = 1'b1;
      typedefs::JMP: is_jmp = 1'b1;
      default: ;
    endcase
  end

  // Next state: linear advance with wrap, except HLT parks in OP_ADDR.
  // Parking is stable since load_ir is low there and the opcode cannot change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INST_ADDR:  state_d = INST_FETCH;
      INST_FETCH: state_d = INST_LOAD;
      INST_LOAD:  state_d = IDLE;
      IDLE:       state_d = OP_ADDR;
      OP_ADDR:    state_d = is_hlt ? OP_ADDR : OP_FETCH;
      OP_FETCH:   state_d = ALU_OP;
      ALU_OP:     state_d = STORE;
      STORE:      state_d = INST_ADDR;
      default:    state_d = INST_ADDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state_q <= INST_ADDR;
    else       state_q <= state_d;
  end

  // Strobe decode.
  always_comb begin
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    case (state_q)
      INST_ADDR: ;
      INST_FETCH: mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        halt   = is_hlt;
        // Explicit non-HLT opcode rather than !is_hlt so X opcode stays quiet.
        inc_pc = is_skz | aluop | is_sto | is_jmp;
      end
      OP_FETCH: mem_rd = aluop;
      ALU_OP: begin
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = is_skz & (zero === 1'b1);
        load_pc = is_jmp;
      end
      STORE: begin
        mem_rd  = aluop;
        load_ac = aluop;
        inc_pc  = is_jmp;
        load_pc = is_jmp;
        mem_wr  = is_sto;
      end
      default: ;
    endcase
  end

`ifdef CONTROLLER_INSTR_COUNT_EN
  // Retired-instruction counter: bumps on the edge leaving STORE, saturates.
  // A halted sequencer never reaches STORE, so it stops counting by itself.
  logic [15:0] instr_count_q, instr_count_d;

  always_comb begin
    instr_count_d = instr_count_q;
    if (state_q == STORE && instr_count_q != 16'hFFFF)
      instr_count_d = instr_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) instr_count_q <= 16'd0;
    else       instr_count_q <= instr_count_d;
  end

  assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_controller.sv
// -----------------------------------------------------------------------------
// tb_controller -- directed self-checking bench for controller.
// Outputs are sampled on the negedge (mid-state). Expected strobe vectors are
// packed as {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_controller;

  logic       clk;
  logic       rst_;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;
`ifdef CONTROLLER_INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  int checks = 0;
  int errors = 0;

  controller dut (
    .clk     (clk),
    .rst_    (rst_),
    .opcode  (opcode),
    .zero    (zero),
    .mem_rd  (mem_rd),
    .load_ir (load_ir),
    .halt    (halt),
    .inc_pc  (inc_pc),
    .load_ac (load_ac),
    .load_pc (load_pc),
    .mem_wr  (mem_wr)
`ifdef CONTROLLER_INSTR_COUNT_EN
    ,
    .instr_count (instr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] strobes();
    return {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr};
  endfunction

  task automatic check_vec(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = strobes();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    // Structural exclusions must hold in every sampled state.
    checks++;
    assert (!(mem_rd && mem_wr) && !(load_ac && mem_wr)) else begin
      errors++;
      $error("FAIL %s_excl observed=%b expected=no rd/wr or ac/wr overlap", tag, obs);
    end
  endtask

  // Called while in INST_ADDR mid-cycle; leaves the bench in the next
  // instruction's INST_ADDR mid-cycle.
  task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                           input logic [7:0][6:0] exp);
    opcode = op;
    zero   = z;
    for (int p = 0; p < 8; p++) begin
      check_vec($sformatf("%s_s%0d", name, p), exp[p]);
      @(negedge clk);
    end
  endtask

  // Phase-fixed part shared by every opcode: states 0..3.
  localparam logic [6:0] S0 = 7'b0000000;
  localparam logic [6:0] S1 = 7'b1000000;
  localparam logic [6:0] S2 = 7'b1100000;

  initial begin
    rst_   = 1'b0;
    opcode = 3'd2;
    zero   = 1'b0;

    // Reset held for 3 clocks.
    repeat (3) @(posedge clk);
    #1 check_vec("reset_hold", 7'b0000000);
    @(negedge clk);
    #1 rst_ = 1'b1;
    check_vec("reset_release", 7'b0000000);

    // exp[p] indexes state p (packed [7:0], so list from state 7 down to 0).
    run_instr("add", 3'd2, 1'b0,
      {7'b1000100, 7'b1000100, 7'b1000000, 7'b0001000, S2, S2, S1, S0});
    run_instr("xor_z1", 3'd4, 1'b1,
      {7'b1000100, 7'b1000100, 7'b1000000, 7'b0001000, S2, S2, S1, S0});
    run_instr("skz_z1", 3'd1, 1'b1,
      {7'b0000000, 7'b0001000, 7'b0000000, 7'b0001000, S2, S2, S1, S0});
    run_instr("skz_z0", 3'd1, 1'b0,
      {7'b0000000, 7'b0000000, 7'b0000000, 7'b0001000, S2, S2, S1, S0});
    run_instr("sto", 3'd6, 1'b1,
      {7'b0000001, 7'b0000000, 7'b0000000, 7'b0001000, S2, S2, S1, S0});
    run_instr("jmp", 3'd7, 1'b0,
      {7'b0001010, 7'b0000010, 7'b0000000, 7'b0001000, S2, S2, S1, S0});
    run_instr("and", 3'd3, 1'b0,
      {7'b1000100, 7'b1000100, 7'b1000000, 7'b0001000, S2, S2, S1, S0});

    // HLT: through the fetch phases, then parked in OP_ADDR.
    opcode = 3'd0;
    zero   = 1'b0;
    check_vec("hlt_s0", S0);
    @(negedge clk); check_vec("hlt_s1", S1);
    @(negedge clk); check_vec("hlt_s2", S2);
    @(negedge clk); check_vec("hlt_s3", S2);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      check_vec($sformatf("hlt_hold%0d", i), 7'b0010000);
    end
    // Asynchronous reset mid-cycle drops halt without waiting for an edge.
    #2 rst_ = 1'b0;
    #1 check_vec("hlt_async_reset", 7'b0000000);
    @(negedge clk);
    #1 rst_ = 1'b1;
    check_vec("post_hlt_release", 7'b0000000);
    opcode = 3'd5;
    @(negedge clk); check_vec("post_hlt_s1", S1);
    @(negedge clk);

    // Reset in the middle of an instruction abandons it.
    @(negedge clk);
    @(negedge clk);
    check_vec("mid_s4_pre", 7'b0001000);
    #2 rst_ = 1'b0;
    #1 check_vec("mid_reset", 7'b0000000);
    @(posedge clk);
    #1 check_vec("mid_reset_edge", 7'b0000000);
    @(negedge clk);
    #1 rst_ = 1'b1;

`ifdef CONTROLLER_INSTR_COUNT_EN
    checks++;
    assert (instr_count === 16'd0) else begin
      errors++;
      $error("FAIL cnt_reset observed=%0d expected=0", instr_count);
    end
    for (int k = 0; k < 5; k++)
      run_instr($sformatf("lda%0d", k), 3'd5, 1'b0,
        {7'b1000100, 7'b1000100, 7'b1000000, 7'b0001000, S2, S2, S1, S0});
    checks++;
    assert (instr_count === 16'd5) else begin
      errors++;
      $error("FAIL cnt_five observed=%0d expected=5", instr_count);
    end
    force dut.instr_count_q = 16'hFFFF;
    #1 release dut.instr_count_q;
    run_instr("lda_sat", 3'd5, 1'b0,
      {7'b1000100, 7'b1000100, 7'b1000000, 7'b0001000, S2, S2, S1, S0});
    checks++;
    assert (instr_count === 16'hFFFF) else begin
      errors++;
      $error("FAIL cnt_sat observed=%h expected=ffff", instr_count);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
